icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped, one-word-per-frame instruction cache between the pipeline fetch
//  stage (imemREN/imemaddr -> ihit/imemload) and the memory controller (iREN/iaddr <- iload/iwait).
//  Hits return the instruction in the same cycle. Misses run a blocking fill FSM.
//  Hit and miss counters are provided for performance reporting.
// PARAMETERS
//  IDX_BITS   4    log2(number of frames); default 16 frames
//  CNT_W      32   width of hit_count / miss_count
// PORTS
//  CLK         in   1      clock, rising edge
//  nRST        in   1      reset, asynchronous, active-low
//  imemREN     in   1      fetch request from the datapath
//  imemaddr    in   32     fetch byte address; bits [1:0] are ignored
//  ihit        out  1      imemload is valid this cycle
//  imemload    out  32     instruction word
//  flush       in   1      synchronous invalidate of all frames
//  iREN        out  1      read request to the memory controller
//  iaddr       out  32     word-aligned miss address
//  iload       in   32     data from the memory controller
//  iwait       in   1      1 = memory is busy; iload is valid in the cycle iwait==0
//  hit_count   out  CNT_W  number of hits seen
//  miss_count  out  CNT_W  number of misses seen
// BEHAVIOUR
//  Address split: tag=imemaddr[31:IDX_BITS+2], idx=imemaddr[IDX_BITS+1:2].
//  Per-frame storage: valid, tag, data. Frame arrays are NOT reset; only the valid bits are.
//  Reset values: valid=0, state=IDLE, iREN=0, iaddr=0, ihit=0, imemload=0, both counters=0.
//  hit = (state==IDLE) & imemREN & valid[idx] & (tag==stored tag).
//  ihit = hit, combinational. imemload = data[idx] when hit, else 0.
//  FSM states:
//   IDLE:  on hit, stay in IDLE.
//          On imemREN & !hit, latch miss_addr={imemaddr[31:2],2'b00}, go to FETCH,
//          and increment miss_count once.
//          imemREN==0 never starts a fill.
//   FETCH: iREN=1, iaddr=miss_addr, ihit=0.
//          On iwait==0: write valid=1, tag and data=iload into frame idx(miss_addr); go to IDLE.
//          While iwait==1: stay in FETCH.
//  Miss latency: fill completes on the first cycle iwait==0. The re-presented address hits
//   in the cycle after the fill. Minimum miss penalty is 2 cycles.
//  Address change or imemREN drop during FETCH: the fill of miss_addr still completes.
//   The new address is then evaluated in IDLE.
//  Conflict misses: the fill overwrites the frame unconditionally (direct-mapped, no replacement choice).
//  hit_count increments on every cycle where ihit=1.
//  Both counters saturate at all-ones; they never wrap.
//  flush:
//   In IDLE: clears all valid bits at the next edge; ihit is forced to 0 in the flush cycle.
//   In FETCH: the in-flight fill completes but is written with valid=0; all other valid bits clear.
//  Reset mid-FETCH: returns to IDLE with all frames invalid and iREN=0 immediately (async).
//  No write path: the instruction cache is read-only; self-modifying code needs flush.
// TESTING
//  1 Cold miss: reset, imemREN=1, addr 0x0000_0004, iwait=1 for 3 cycles then 0 with iload=0x2008_0001
//    -> iREN=1, iaddr=0x4 for 4 cycles; next cycle ihit=1, imemload=0x2008_0001; miss_count=1.
//  2 Repeat hit: hold addr 0x4 for 5 cycles after fill -> ihit=1 every cycle, iREN=0, hit_count=5.
//  3 Conflict: fill 0x0000_0040 (idx 0), then fill 0x0000_0000 (idx 0), then request 0x40
//    -> third access misses again; miss_count=3.
//  4 Address change mid-FETCH: miss on 0x8, switch to 0xC while iwait=1
//    -> iaddr stays 0x8; after fill, 0xC misses; 0x8 hits later.
//  5 Flush: fill idx 1 and idx 2, pulse flush for 1 cycle -> both addresses miss afterwards.
//    Flush during FETCH -> filled frame reads invalid.
//  6 Reset mid-FETCH: drop nRST with iwait=1 -> iREN=0 asynchronously, counters=0, prior lines miss.
//    imemREN=0 with iwait toggling -> iREN never asserts.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-frame instruction cache.
// Hits are answered combinationally. A miss runs a blocking fill from the
// memory controller. Saturating hit and miss counters support performance
// reporting.
//
// Memory-side handshake: iREN is held high with a stable iaddr for the whole
// fill. The controller answers by dropping iwait; iload is valid only in the
// cycle where iREN==1 and iwait==0. That cycle writes the frame and returns
// the FSM to IDLE.
module icache_dm #(
    parameter int IDX_BITS = 4,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    input  logic             flush,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic [31:0]      iload,
    input  logic             iwait,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int NFRAMES = 1 << IDX_BITS;
    localparam int TAG_W   = 32 - IDX_BITS - 2;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                state_q;
    logic                  iren_q;
    logic [31:0]           iaddr_q;       // doubles as the latched miss address
    logic                  flush_pend_q;  // a flush arrived while the fill was in flight
    logic [NFRAMES-1:0]    valid_q;
    logic [NFRAMES-1:0]    valid_d;
    logic [TAG_W-1:0]      tag_q  [NFRAMES];
    logic [31:0]           data_q [NFRAMES];
    logic [CNT_W-1:0]      hit_cnt_q;
    logic [CNT_W-1:0]      miss_cnt_q;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic [IDX_BITS-1:0]   fill_idx;
    logic                  hit_raw;
    logic                  miss_start;
    logic                  fill_done;

    // Byte-offset bits of the fetch address carry no information.
    logic                  unused_addr_bits;
    assign unused_addr_bits = &{1'b0, imemaddr[1:0]};

    assign req_tag  = imemaddr[31:IDX_BITS+2];
    assign req_idx  = imemaddr[IDX_BITS+1:2];
    assign fill_tag = iaddr_q[31:IDX_BITS+2];
    assign fill_idx = iaddr_q[IDX_BITS+1:2];

    // A flush does not suppress the lookup itself, only the reported hit, so a
    // flushed hit neither starts a fill nor counts as a hit.
    assign hit_raw    = (state_q == IDLE) & imemREN & valid_q[req_idx] &
                        (tag_q[req_idx] == req_tag);
    assign miss_start = (state_q == IDLE) & imemREN & ~hit_raw;
    assign fill_done  = (state_q == FETCH) & ~iwait;

    assign ihit       = hit_raw & ~flush;
    assign imemload   = ihit ? data_q[req_idx] : 32'h0;
    assign iREN       = iren_q;
    assign iaddr      = iaddr_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Fill FSM: latches the miss address and holds the memory request until iwait drops.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            iren_q       <= 1'b0;
            iaddr_q      <= 32'h0;
            flush_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    flush_pend_q <= 1'b0;
                    if (miss_start) begin
                        state_q <= FETCH;
                        iren_q  <= 1'b1;
                        iaddr_q <= {imemaddr[31:2], 2'b00};
                    end
                end
                FETCH: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (!iwait) begin
                        state_q      <= IDLE;
                        iren_q       <= 1'b0;
                        flush_pend_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    iren_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next valid vector: flush clears everything, and a fill that saw a flush lands invalid.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end
        if (fill_done) begin
            valid_d[fill_idx] = ~(flush | flush_pend_q);
        end
    end

    // Valid bits are the only part of the frame store that is reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays: written only on fill completion, never reset.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (ihit && (hit_cnt_q != {CNT_W{1'b1}})) begin
                hit_cnt_q <= hit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (miss_start && (miss_cnt_q != {CNT_W{1'b1}})) begin
                miss_cnt_q <= miss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Testbench for icache_dm: directed scenarios followed by a short random phase.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_icache_dm;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of instruction words expected on the next hit.
    logic [31:0] exp_q[$];
    // Reference counters and a tag/valid model of the 16 frames.
    int          exp_hc = 0;
    int          exp_mc = 0;
    bit          mv [16];
    logic [25:0] mt [16];

    icache_dm #(.IDX_BITS(4), .CNT_W(32)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .flush      (flush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iload      (iload),
        .iwait      (iwait),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Clock and watchdog.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0004) return 32'h2008_0001;
        return ({a[15:0], 16'h0} ^ 32'h1357_9bdf) + a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    task automatic model_fill(input logic [31:0] a);
        mv[a[5:2]] = 1'b1;
        mt[a[5:2]] = a[31:6];
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return mv[a[5:2]] && (mt[a[5:2]] == a[31:6]);
    endfunction

    // One manually driven cycle; returns 1 time unit after the inputs change.
    task automatic cyc(input bit ren, input logic [31:0] a, input bit fl,
                       input bit wt, input logic [31:0] ld);
        @(negedge CLK);
        imemREN  = ren;
        imemaddr = a;
        flush    = fl;
        iwait    = wt;
        iload    = ld;
        #1;
    endtask

    // Idle cycle used to compare both counters against the reference counts.
    task automatic idle_check(input string tag);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        chk({tag, "_hit_count"}, hit_count, exp_hc);
        chk({tag, "_miss_count"}, miss_count, exp_mc);
    endtask

    // Presents address a until ihit, acting as the memory controller with
    // 'waits' busy cycles before delivering the word.
    task automatic fetch(input logic [31:0] a, input bit exp_miss,
                         input int waits, output int ren_cyc);
        int w;
        bit done;
        bit missed;
        w       = waits;
        done    = 1'b0;
        missed  = 1'b0;
        ren_cyc = 0;
        exp_q.push_back(mem_word(a));
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge CLK);
            imemREN  = 1'b1;
            imemaddr = a;
            flush    = 1'b0;
            if (iREN === 1'b1) begin
                missed = 1'b1;
                ren_cyc++;
                chk("iaddr", iaddr, {a[31:2], 2'b00});
                if (w > 0) begin
                    iwait = 1'b1;
                    iload = $urandom;
                    w--;
                end else begin
                    iwait = 1'b0;
                    iload = mem_word(a);
                end
            end else begin
                iwait = 1'b1;
                iload = $urandom;
            end
            #1;
            if (ihit === 1'b1) begin
                done = 1'b1;
                chk("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) chk("imemload", imemload, exp_q.pop_front());
                exp_hc++;
            end else begin
                chk("imemload_idle", imemload, 32'h0);
            end
        end
        chk("hit_timeout", done, 1);
        if (!done) exp_q.delete();
        chk("miss_seen", missed, exp_miss);
        if (exp_miss) exp_mc++;
        model_fill(a);
    endtask

    int rc;
    logic [31:0] ra;

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h4;
        flush    = 1'b0;
        iwait    = 1'b1;
        iload    = 32'h0;
        model_clear();
        #1;
        // Reset state.
        chk("rst_ihit", ihit, 0);
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_iREN", iREN, 0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        @(negedge CLK);
        @(negedge CLK);
        nRST    = 1'b1;
        imemREN = 1'b0;

        // 1 Cold miss: three busy cycles, so iREN is high for four cycles.
        fetch(32'h4, 1'b1, 3, rc);
        chk("cold_ren_cycles", rc, 4);
        chk("cold_miss_count", miss_count, 1);

        // 2 Repeat hits: four more cycles on 0x4, five hits in total.
        for (int i = 0; i < 4; i++) begin
            fetch(32'h4, 1'b0, 0, rc);
        end
        idle_check("repeat");
        chk("repeat_hit_count", hit_count, 5);

        // 3 Conflict on frame 0.
        fetch(32'h40, 1'b1, $urandom_range(0, 3), rc);
        fetch(32'h0, 1'b1, $urandom_range(0, 3), rc);
        fetch(32'h40, 1'b1, $urandom_range(0, 3), rc);
        idle_check("conflict");

        // 4 Address switches from 0x8 to 0xC while the fill of 0x8 is busy.
        cyc(1'b1, 32'h8, 1'b0, 1'b1, 32'h0);
        chk("chg_first_ihit", ihit, 0);
        exp_mc++;
        cyc(1'b1, 32'hC, 1'b0, 1'b1, 32'h0);
        chk("chg_iREN_busy", iREN, 1);
        chk("chg_iaddr_busy", iaddr, 32'h8);
        chk("chg_ihit_busy", ihit, 0);
        cyc(1'b1, 32'hC, 1'b0, 1'b0, mem_word(32'h8));
        chk("chg_iREN_fill", iREN, 1);
        chk("chg_iaddr_fill", iaddr, 32'h8);
        model_fill(32'h8);
        cyc(1'b1, 32'hC, 1'b0, 1'b1, 32'h0);
        chk("chg_iREN_after", iREN, 0);
        chk("chg_C_misses", ihit, 0);
        fetch(32'hC, 1'b1, 1, rc);
        fetch(32'h8, 1'b0, 0, rc);
        idle_check("chg");

        // 5a Flush in IDLE: the hit in the flush cycle is suppressed.
        fetch(32'h4, 1'b0, 0, rc);
        fetch(32'h8, 1'b0, 0, rc);
        cyc(1'b1, 32'h4, 1'b1, 1'b1, 32'h0);
        chk("flush_ihit", ihit, 0);
        chk("flush_imemload", imemload, 32'h0);
        model_clear();
        idle_check("flush");
        fetch(32'h4, 1'b1, 0, rc);
        fetch(32'h8, 1'b1, 2, rc);

        // 5b Flush during FETCH: the filled frame stays invalid, others clear.
        cyc(1'b1, 32'h10, 1'b0, 1'b1, 32'h0);
        chk("ff_first_ihit", ihit, 0);
        exp_mc++;
        cyc(1'b1, 32'h10, 1'b1, 1'b1, 32'h0);
        chk("ff_iREN", iREN, 1);
        model_clear();
        cyc(1'b1, 32'h10, 1'b0, 1'b0, mem_word(32'h10));
        chk("ff_iREN_fill", iREN, 1);
        cyc(1'b1, 32'h10, 1'b0, 1'b1, 32'h0);
        chk("ff_refetch_ihit", ihit, 0);
        chk("ff_refetch_iREN", iREN, 0);
        fetch(32'h10, 1'b1, 1, rc);
        fetch(32'h4, 1'b1, 0, rc);
        idle_check("ff");

        // 6 Asynchronous reset in the middle of a fill.
        cyc(1'b1, 32'h20, 1'b0, 1'b1, 32'h0);
        chk("rm_first_ihit", ihit, 0);
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        chk("rm_iREN_before", iREN, 1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rm_iREN", iREN, 0);
        chk("rm_iaddr", iaddr, 32'h0);
        chk("rm_hit_count", hit_count, 0);
        chk("rm_miss_count", miss_count, 0);
        exp_hc = 0;
        exp_mc = 0;
        model_clear();
        exp_q.delete();
        imemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        // No request, iwait toggling: no fill may start.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, $urandom, 1'b0, i[0], $urandom);
            chk("noreq_iREN", iREN, 0);
        end
        idle_check("noreq");
        fetch(32'h4, 1'b1, 0, rc);
        fetch(32'h8, 1'b1, 1, rc);

        // Random accesses over four tags and all sixteen frames.
        for (int i = 0; i < 24; i++) begin
            ra = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            fetch(ra, !model_hit(ra), $urandom_range(0, 3), rc);
        end
        idle_check("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
